pov_spi_loader: RTL and testbench
=================================

# pov_spi_loader

Serial loader for the six fixed-point point-of-view vectors (playerX, playerY, facingX, facingY, vplaneX, vplaneY) consumed by the tracer and the debug overlay. It receives a 6×W-bit frame over a mode-0 SPI-style link (sclk/mosi/csb) and holds it in a shadow buffer. It commits the whole set atomically to its outputs on a frame-boundary strobe, so the renderer never sees a half-updated view.

## Interface
Parameters:
- QM, 10, integer bits per vector
- QN, 12, fractional bits per vector; W = QM+QN = 22, FRAME_BITS = 6*W = 132

Ports:
- clk  input  1  system clock (pixel clock domain)
- rst_n  input  1  reset, asynchronous and active-low
- sclk  input  1  serial clock, asynchronous to clk, idle low
- mosi  input  1  serial data, changes on sclk falling edge, sampled on rising edge
- csb  input  1  chip select, active low, asynchronous to clk
- load_strobe  input  1  one-cycle frame-boundary pulse in clk domain (end of visible frame)
- playerX, playerY, facingX, facingY, vplaneX, vplaneY  output  W each  committed vectors, two's complement, value = integer/2^QN
- pending  output  1  shadow buffer holds a complete, uncommitted frame
- committed  output  1  one-cycle pulse: outputs updated this cycle
- frame_error  output  1  one-cycle pulse: transfer ended with bit count ≠ FRAME_BITS

## Operation
- sclk, mosi, csb each pass through a 2-flop synchronizer; sclk and csb edges are detected from the synchronized value and its one-cycle-delayed copy.
- csb synchronized falling edge: clear bit counter; shift register is not cleared.
- csb low and sclk synchronized rising edge: shift synchronized mosi into LSB of a FRAME_BITS shift register (MSB first overall); counter increments and saturates at FRAME_BITS+1.
- Frame order, first bit first: playerX[W-1] … playerX[0], playerY, facingX, facingY, vplaneX, vplaneY. After a full frame, playerX occupies shift[FRAME_BITS-1 -: W].
- sclk edges while csb high are ignored.
- csb synchronized rising edge:
  - counter == FRAME_BITS: copy shift register to shadow buffer, set pending. A newer frame overwrites an uncommitted one (latest wins).
  - Otherwise: shadow and pending unchanged, pulse frame_error.
- load_strobe with pending=1: shadow → outputs, clear pending, pulse committed. With pending=0: no effect.
- Simultaneous csb rising edge (valid frame) and load_strobe: commit uses the old shadow; the new frame lands in shadow and pending stays 1 after that cycle. If pending was 0, the new frame is not committed until the next load_strobe.
- Reset values:
  - playerX = playerY = 1.5 (0x001800 pattern, i.e. 3<<(QN-1))
  - facingX = 0
  - facingY = 1.0 (1<<QN)
  - vplaneX = -0.5 (two's complement of 1<<(QN-1))
  - vplaneY = 0
  - shadow = same as outputs; pending, committed, frame_error, counter, synchronizer flops = 0; synchronized csb resets to 1.

## Timing
- Synchronizer latency: an sclk/csb edge is acted on at the 3rd clk rising edge after it occurs.
- Input constraint: sclk high and low ≥ 3 clk periods each; csb setup/hold to first/last sclk edge ≥ 3 clk periods.
- Shadow/pending update: same clk edge as the csb rising-edge detect.
- Output update: the clk edge that samples load_strobe=1. committed is high for exactly that following cycle. frame_error is high for one cycle after the csb-rise detect.
- Outputs change only on commit; they never change during a transfer.
- rst_n assertion mid-transfer or mid-pending: immediate return to reset values. A partial frame is discarded with no frame_error. After deassertion, a new csb falling edge is required.

## Test plan
- Reset: hold rst_n low, release -> playerX=0x001800, facingY=0x001000, vplaneX=0x3FF800 (22-bit), pending=0, committed=0.
- Valid frame: send 132 bits with playerX=0x0ABCDE, playerY=0x012345, facingX=0x3FF000, facingY=0, vplaneX=0x000800, vplaneY=0x3FFFFF, then raise csb -> pending=1, outputs unchanged. Pulse load_strobe -> outputs equal the sent values, committed pulses once, pending=0.
- Short/long frame: send 131 bits, then 133 bits -> frame_error pulses each time, pending stays 0, and load_strobe does not change the outputs.
- Latest wins: send frame A (playerX=0x000001), then frame B (playerX=0x000002) with no strobe, then strobe -> playerX=0x000002.
- Simultaneous: with frame A pending, complete frame B so csb-rise detect and load_strobe occur on the same cycle -> outputs=A, pending=1. Next strobe -> outputs=B.
- Reset mid-transfer: assert rst_n after 60 bits -> reset values restored, no frame_error. A full 132-bit frame afterwards loads correctly.

Source files
------------

// File: rtl/pov_spi_loader_if.sv
// Serial link carrying one point-of-view frame into the loader.
// Handshake: there is no valid/ready pair on this link; a transfer is framed by
// csb low, each bit is qualified by a rising sclk edge while csb is low, and a
// transfer is accepted only if exactly one full frame was clocked before csb rises.
interface pov_spi_loader_if;
  logic sclk;
  logic mosi;
  logic csb;

  modport master (output sclk, output mosi, output csb);
  modport slave  (input  sclk, input  mosi, input  csb);
endinterface

// File: rtl/pov_spi_loader.sv
// Point-of-view vector loader: receives a 6-vector frame over a mode-0 serial
// link into a shift register, parks complete frames in a shadow buffer and
// commits the shadow to the outputs atomically on the frame-boundary strobe.
module pov_spi_loader #(
  parameter int QM = 10,
  parameter int QN = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pov_spi_loader_if.slave      spi,
  input  logic                 load_strobe,
  output logic [QM+QN-1:0]     playerX,
  output logic [QM+QN-1:0]     playerY,
  output logic [QM+QN-1:0]     facingX,
  output logic [QM+QN-1:0]     facingY,
  output logic [QM+QN-1:0]     vplaneX,
  output logic [QM+QN-1:0]     vplaneY,
  output logic                 pending,
  output logic                 committed,
  output logic                 frame_error
);

  localparam int W          = QM + QN;
  localparam int FRAME_BITS = 6 * W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  // Default view: player at (1.5, 1.5) facing +Y with a half-width camera plane.
  localparam logic [W-1:0] RST_POS   = W'(3 << (QN - 1));
  localparam logic [W-1:0] RST_ONE   = W'(1 << QN);
  localparam logic [W-1:0] RST_NHALF = W'(-(1 << (QN - 1)));
  localparam logic [W-1:0] RST_ZERO  = '0;
  localparam logic [FRAME_BITS-1:0] RESET_FRAME =
    {RST_POS, RST_POS, RST_ZERO, RST_ONE, RST_NHALF, RST_ZERO};

  logic sclk_s1, sclk_s2, sclk_d;
  logic mosi_s1, mosi_s2;
  logic csb_s1, csb_s2, csb_d;

  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] shadow_q;
  logic [FRAME_BITS-1:0] out_q;

  logic sclk_rise, csb_fall, csb_rise, frame_ok;

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign csb_fall  = csb_d & ~csb_s2;
  assign csb_rise  = ~csb_d & csb_s2;
  assign frame_ok  = csb_rise && (bit_cnt == CNT_FULL);

  // Two-flop synchronizers plus one delayed copy for edge detection; csb idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      csb_s1  <= 1'b1;
      csb_s2  <= 1'b1;
      csb_d   <= 1'b1;
    end else begin
      sclk_s1 <= spi.sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      mosi_s1 <= spi.mosi;
      mosi_s2 <= mosi_s1;
      csb_s1  <= spi.csb;
      csb_s2  <= csb_s1;
      csb_d   <= csb_s2;
    end
  end

  // Bit capture: MSB-first shift while selected, count saturating one past a full frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (csb_fall) begin
      bit_cnt <= '0;
    end else if (!csb_s2 && sclk_rise) begin
      shift_q <= {shift_q[FRAME_BITS-2:0], mosi_s2};
      if (bit_cnt != CNT_SAT) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Shadow/commit: the strobe commits the old shadow; a frame landing on the same
  // edge overwrites the shadow afterwards and keeps pending set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= RESET_FRAME;
      out_q       <= RESET_FRAME;
      pending     <= 1'b0;
      committed   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      committed   <= 1'b0;
      frame_error <= csb_rise && !frame_ok;
      if (load_strobe && pending) begin
        out_q     <= shadow_q;
        pending   <= 1'b0;
        committed <= 1'b1;
      end
      if (frame_ok) begin
        shadow_q <= shift_q;
        pending  <= 1'b1;
      end
    end
  end

  assign playerX = out_q[FRAME_BITS-1   -: W];
  assign playerY = out_q[FRAME_BITS-1-W -: W];
  assign facingX = out_q[4*W-1 -: W];
  assign facingY = out_q[3*W-1 -: W];
  assign vplaneX = out_q[2*W-1 -: W];
  assign vplaneY = out_q[W-1   -: W];

endmodule

// File: tb/tb_pov_spi_loader.sv
// Directed bench for pov_spi_loader with a transaction-level reference model.
module tb_pov_spi_loader;

  localparam int W  = 22;
  localparam int FB = 6 * W;

  localparam logic [FB-1:0] RESET_VIEW =
    {22'h001800, 22'h001800, 22'h000000, 22'h001000, 22'h3FF800, 22'h000000};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_strobe = 1'b0;
  always #5 clk = ~clk;

  pov_spi_loader_if spi_bus ();

  logic [W-1:0] player_x, player_y, facing_x, facing_y, vplane_x, vplane_y;
  logic pending, committed, frame_error;

  pov_spi_loader #(.QM(10), .QN(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi         (spi_bus),
    .load_strobe (load_strobe),
    .playerX     (player_x),
    .playerY     (player_y),
    .facingX     (facing_x),
    .facingY     (facing_y),
    .vplaneX     (vplane_x),
    .vplaneY     (vplane_y),
    .pending     (pending),
    .committed   (committed),
    .frame_error (frame_error)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
    end
  endtask

  // ---------------- reference model ----------------
  // A transfer ended by the driver takes effect on the 3rd clk edge after csb
  // rises; the strobe takes effect on the edge that samples it.
  int cyc = 0;
  int end_cyc = -10;
  int end_cnt = 0;
  logic [FB-1:0] end_frame = '0;

  logic [FB-1:0] m_out, m_shadow;
  logic m_pending, m_committed, m_ferr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out       <= RESET_VIEW;
      m_shadow    <= RESET_VIEW;
      m_pending   <= 1'b0;
      m_committed <= 1'b0;
      m_ferr      <= 1'b0;
    end else begin
      m_committed <= load_strobe && m_pending;
      m_ferr      <= (cyc == end_cyc) && (end_cnt != FB);
      if (load_strobe && m_pending) m_out <= m_shadow;
      if ((cyc == end_cyc) && (end_cnt == FB)) begin
        m_shadow  <= end_frame;
        m_pending <= 1'b1;
      end else if (load_strobe && m_pending) begin
        m_pending <= 1'b0;
      end
    end
  end

  // One compare process, every cycle, away from the active edge.
  always @(negedge clk) begin
    check("playerX",     32'(player_x),    32'(m_out[FB-1 -: W]));
    check("playerY",     32'(player_y),    32'(m_out[FB-1-W -: W]));
    check("facingX",     32'(facing_x),    32'(m_out[4*W-1 -: W]));
    check("facingY",     32'(facing_y),    32'(m_out[3*W-1 -: W]));
    check("vplaneX",     32'(vplane_x),    32'(m_out[2*W-1 -: W]));
    check("vplaneY",     32'(vplane_y),    32'(m_out[W-1 -: W]));
    check("pending",     32'(pending),     32'(m_pending));
    check("committed",   32'(committed),   32'(m_committed));
    check("frame_error", 32'(frame_error), 32'(m_ferr));
  end

  int ferr_seen = 0;
  int commit_seen = 0;
  always @(negedge clk) begin
    if (frame_error) ferr_seen++;
    if (committed) commit_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [FB-1:0] mk(input logic [W-1:0] px, py, fx, fy, vx, vy);
    return {px, py, fx, fy, vx, vy};
  endfunction

  // Select the link and clock n bits, MSB of f first; bits beyond a frame are 1.
  task automatic send_bits(input logic [FB-1:0] f, input int n);
    spi_bus.csb = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < n; i++) begin
      spi_bus.mosi = (i < FB) ? f[FB-1-i] : 1'b1;
      wait_cyc(4);
      spi_bus.sclk = 1'b1;
      wait_cyc(4);
      spi_bus.sclk = 1'b0;
    end
    wait_cyc(4);
  endtask

  task automatic end_xfer(input logic [FB-1:0] f, input int n);
    spi_bus.csb = 1'b1;
    end_frame   = f;
    end_cnt     = n;
    end_cyc     = cyc + 2;
  endtask

  task automatic send_frame(input logic [FB-1:0] f, input int n);
    send_bits(f, n);
    end_xfer(f, n);
    wait_cyc(6);
  endtask

  task automatic pulse_strobe();
    load_strobe = 1'b1;
    wait_cyc(1);
    load_strobe = 1'b0;
    wait_cyc(2);
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  initial begin
    #3ms;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: run did not complete, expected completion before 3ms");
    finish_run();
  end

  // ---------------- directed stimulus ----------------
  logic [FB-1:0] f1, fa, fb, fc, fd;
  int ferr_base;

  initial begin
    f1 = mk(22'h0ABCDE, 22'h012345, 22'h3FF000, 22'h000000, 22'h000800, 22'h3FFFFF);
    fa = mk(22'h000001, 22'h000010, 22'h000020, 22'h000030, 22'h000040, 22'h000050);
    fb = mk(22'h000002, 22'h000011, 22'h000021, 22'h000031, 22'h000041, 22'h000051);
    fc = mk(22'h000003, 22'h1FFFFF, 22'h200000, 22'h2AAAAA, 22'h155555, 22'h000007);
    fd = mk(22'h000004, 22'h3C0F0F, 22'h00F0F0, 22'h123456, 22'h3EDCBA, 22'h000009);

    spi_bus.sclk = 1'b0;
    spi_bus.mosi = 1'b0;
    spi_bus.csb  = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(3);

    // Reset values
    check("rst playerX", 32'(player_x), 32'h001800);
    check("rst facingY", 32'(facing_y), 32'h001000);
    check("rst vplaneX", 32'(vplane_x), 32'h3FF800);
    check("rst pending", 32'(pending), 32'h0);
    check("rst committed", 32'(committed), 32'h0);

    // Valid frame: parked until the strobe
    send_frame(f1, FB);
    check("f1 pending", 32'(pending), 32'h1);
    check("f1 held playerX", 32'(player_x), 32'h001800);
    pulse_strobe();
    check("f1 playerX", 32'(player_x), 32'h0ABCDE);
    check("f1 playerY", 32'(player_y), 32'h012345);
    check("f1 facingX", 32'(facing_x), 32'h3FF000);
    check("f1 vplaneX", 32'(vplane_x), 32'h000800);
    check("f1 vplaneY", 32'(vplane_y), 32'h3FFFFF);
    check("f1 pending clr", 32'(pending), 32'h0);
    check("f1 commit pulses", 32'(commit_seen), 32'd1);

    // Short and long frames
    ferr_base = ferr_seen;
    send_frame(fa, FB - 1);
    send_frame(fa, FB + 1);
    check("bad frame errors", 32'(ferr_seen - ferr_base), 32'd2);
    check("bad frame pending", 32'(pending), 32'h0);
    pulse_strobe();
    check("bad frame playerX", 32'(player_x), 32'h0ABCDE);

    // Latest wins
    send_frame(fa, FB);
    send_frame(fb, FB);
    pulse_strobe();
    check("latest playerX", 32'(player_x), 32'h000002);
    check("latest vplaneY", 32'(vplane_y), 32'h000051);

    // Strobe coincides with the frame landing
    send_frame(fc, FB);
    send_bits(fd, FB);
    end_xfer(fd, FB);
    wait_cyc(2);
    load_strobe = 1'b1;
    wait_cyc(1);
    load_strobe = 1'b0;
    wait_cyc(2);
    check("simul playerX", 32'(player_x), 32'h000003);
    check("simul facingY", 32'(facing_y), 32'h2AAAAA);
    check("simul pending", 32'(pending), 32'h1);
    pulse_strobe();
    check("simul next playerX", 32'(player_x), 32'h000004);
    check("simul next vplaneX", 32'(vplane_x), 32'h3EDCBA);

    // Reset during a transfer
    ferr_base = ferr_seen;
    send_bits(fa, 60);
    rst_n = 1'b0;
    spi_bus.csb  = 1'b1;
    spi_bus.sclk = 1'b0;
    wait_cyc(3);
    check("midrst playerX", 32'(player_x), 32'h001800);
    rst_n = 1'b1;
    wait_cyc(6);
    check("midrst vplaneX", 32'(vplane_x), 32'h3FF800);
    check("midrst pending", 32'(pending), 32'h0);
    check("midrst no error", 32'(ferr_seen - ferr_base), 32'd0);
    send_frame(f1, FB);
    pulse_strobe();
    check("post rst playerX", 32'(player_x), 32'h0ABCDE);
    check("post rst vplaneY", 32'(vplane_y), 32'h3FFFFF);

    wait_cyc(4);
    finish_run();
  end

endmodule
